branch_hazard_ctrl: RTL and testbench
=====================================

BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset:
- CLK  input  1  rising-edge clock
- RESET_N  input  1  asynchronous active-low reset
REQ-002 The block SHALL have these data and control ports:
- Instruction_ID  input  32  instruction in ID stage
- RegWrite_EX  input  1  EX-stage instruction writes rd
- MemRead_EX  input  1  EX-stage instruction is a load
- rd_EX  input  5  EX-stage destination
- RegWrite_MEM  input  1  MEM-stage instruction writes rd
- MemRead_MEM  input  1  MEM-stage instruction is a load
- rd_MEM  input  5  MEM-stage destination
- ext_stall  input  1  global pipeline freeze (memory wait)
- PCSrc_cmp  input  2  branch comparator result (00 seq, 01 PC+imm, 10 rs1+imm)
- cmp_enable  output  1  comparator enable
- stall  output  1  hold PC and IF/ID; bubble into ID/EX
- flush_IF  output  1  squash IF/ID at next edge
- PCSrc  output  2  PC mux select to fetch

Function
REQ-003 Control-flow decode SHALL use opcode Instruction_ID[6:0]: BRANCH 1100011, JALR 1100111, JAL 1101111; rs1 = [19:15], rs2 = [24:20].
REQ-004 A hazard SHALL exist only when the producer's rd is not 0, its RegWrite is 1, and rd equals rs1 (BRANCH or JALR) or rs2 (BRANCH only); JAL SHALL never hazard.
REQ-005 Required stall count SHALL be:
- 2 for a load in EX matching;
- 1 for a non-load in EX matching, or a load in MEM matching;
- else 0.
- EX takes priority over MEM.
REQ-006 The FSM SHALL have four states: IDLE, STALL, RESOLVE and FLUSHED, and a 2-bit stall counter.
REQ-007 In IDLE with BRANCH/JALR and stall count N>0:
- stall=1, cmp_enable=0 this cycle;
- load counter with N-1;
- next state is STALL if N-1>0, else RESOLVE.
REQ-008 In IDLE with stall count 0, or with JAL, the block SHALL resolve in the same cycle (RESOLVE behaviour, REQ-010) without changing state.
REQ-009 In STALL:
- stall=1, cmp_enable=0;
- counter decrements;
- move to RESOLVE when the counter reaches 0.
- Hazard inputs SHALL be ignored, because the bubbles make them invalid.
REQ-010 In RESOLVE, and in the same-cycle resolve of IDLE:
- cmp_enable=1 and stall=0;
- PCSrc = PCSrc_cmp;
- if PCSrc_cmp≠00: flush_IF=1 and next state FLUSHED, else next state IDLE.
REQ-011 In FLUSHED, Instruction_ID SHALL be ignored for one cycle: all outputs 0, next state IDLE.
REQ-012 Non-control-flow instructions in IDLE SHALL produce all outputs 0.
REQ-013 While ext_stall=1, the block SHALL:
- hold state and counter;
- force cmp_enable=0, flush_IF=0 and PCSrc=00;
- drive stall=1 if the state is STALL or IDLE-with-hazard, else 0.
REQ-014 All outputs SHALL be combinational from state, counter and inputs. Redirect latency SHALL be 0 cycles from the resolve cycle, and the taken penalty SHALL be 1 cycle plus stalls.

Reset
REQ-015 RESET_N=0 SHALL immediately set the state to IDLE and the counter to 0, with stall, flush_IF, cmp_enable and PCSrc at 0, including mid-STALL.
REQ-016 After RESET_N rises, the first edge SHALL evaluate Instruction_ID from IDLE.

Configuration
REQ-017 With macro BRANCH_PERF_EN defined, the block SHALL add three 32-bit outputs:
- br_count: resolved BRANCH/JAL/JALR;
- taken_count: resolves with PCSrc≠00;
- stall_count: cycles with stall=1 and ext_stall=0.
REQ-018 The performance counters SHALL reset to 0, SHALL wrap from FFFFFFFF to 0, and SHALL NOT increment while ext_stall=1.
REQ-019 Without BRANCH_PERF_EN, the ports and counters SHALL be absent and the remaining behaviour identical.

Verification
REQ-020 BEQ x5,x6 in ID, lw x5 in EX → stall=1 for 2 cycles, then cmp_enable=1; if PCSrc_cmp=01 then PCSrc=01 and flush_IF=1, followed by one FLUSHED cycle.
REQ-021 BNE x7,x0 in ID, add x7 in EX → 1 stall, then resolve; PCSrc_cmp=00 → PCSrc=00, flush_IF=0, state IDLE.
REQ-022 JALR with rs1=x1 and lw x1 in MEM → 1 stall, then PCSrc=10, flush_IF=1; JAL with lw x1 in EX → no stall, PCSrc=01.
REQ-023 BEQ x0,x0 with add x0 in EX → no stall, PCSrc=01; BEQ with rd_EX=rs2 but RegWrite_EX=0 → no stall.
REQ-024 ext_stall=1 for 3 cycles mid-STALL → counter held, stall duration extended by 3; RESET_N pulsed low mid-STALL → all outputs 0 with no clock edge.
REQ-025 With BRANCH_PERF_EN, taken_count preloaded to FFFFFFFF plus one taken branch → 00000000; stall_count increments by exactly 2 for the REQ-020 case.

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
// Branch/jump hazard stall and redirect control for branches resolved in the ID stage.
// Optional performance counters are built when BRANCH_PERF_EN is defined.
//
// state   | meaning
// IDLE    | evaluate Instruction_ID; resolve in place when no stall is needed
// STALL   | counting down remaining bubbles, hazard inputs ignored
// RESOLVE | comparator operands valid, drive redirect
// FLUSHED | IF/ID holds a squashed instruction, ignore it for one cycle
module branch_hazard_ctrl (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] Instruction_ID,
    input  logic        RegWrite_EX,
    input  logic        MemRead_EX,
    input  logic [4:0]  rd_EX,
    input  logic        RegWrite_MEM,
    input  logic        MemRead_MEM,
    input  logic [4:0]  rd_MEM,
    input  logic        ext_stall,
    input  logic [1:0]  PCSrc_cmp,
    output logic        cmp_enable,
    output logic        stall,
    output logic        flush_IF,
    output logic [1:0]  PCSrc
`ifdef BRANCH_PERF_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] taken_count,
    output logic [31:0] stall_count
`endif
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2,
        FLUSHED = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] cnt;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       is_branch;
    logic       is_jalr;
    logic       is_jal;
    logic       uses_rs1;
    logic       ex_hit;
    logic       mem_hit;
    logic [1:0] need;
    logic       hazard_idle;
    logic       resolve_now;
    logic       taken;
    logic       unused_bits;

    assign opcode    = Instruction_ID[6:0];
    assign rs1       = Instruction_ID[19:15];
    assign rs2       = Instruction_ID[24:20];
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_jal    = (opcode == OP_JAL);
    assign uses_rs1  = is_branch | is_jalr;
    assign unused_bits = ^{Instruction_ID[31:25], Instruction_ID[14:7]};

    assign ex_hit  = RegWrite_EX && (rd_EX != 5'd0) &&
                     ((uses_rs1 && (rd_EX == rs1)) || (is_branch && (rd_EX == rs2)));
    assign mem_hit = RegWrite_MEM && (rd_MEM != 5'd0) &&
                     ((uses_rs1 && (rd_MEM == rs1)) || (is_branch && (rd_MEM == rs2)));

    // A non-load in MEM is covered by forwarding, so only a MEM load costs a bubble.
    always_comb begin
        need = 2'd0;
        if (ex_hit) begin
            need = MemRead_EX ? 2'd2 : 2'd1;
        end else if (mem_hit && MemRead_MEM) begin
            need = 2'd1;
        end
    end

    assign hazard_idle = uses_rs1 && (need != 2'd0);
    assign resolve_now = (state == RESOLVE) ||
                         ((state == IDLE) && (is_jal || (uses_rs1 && (need == 2'd0))));
    assign taken       = (PCSrc_cmp != 2'b00);

    always_comb begin
        stall      = 1'b0;
        cmp_enable = 1'b0;
        flush_IF   = 1'b0;
        PCSrc      = 2'b00;
        if (RESET_N) begin
            stall = (state == STALL) || ((state == IDLE) && hazard_idle);
            if (resolve_now && !ext_stall) begin
                cmp_enable = 1'b1;
                PCSrc      = PCSrc_cmp;
                flush_IF   = taken;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else if (!ext_stall) begin
            case (state)
                IDLE: begin
                    if (hazard_idle) begin
                        cnt   <= need - 2'd1;
                        state <= (need == 2'd1) ? RESOLVE : STALL;
                    end else if (resolve_now && taken) begin
                        state <= FLUSHED;
                    end
                end
                STALL: begin
                    cnt <= (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
                    if (cnt <= 2'd1) begin
                        state <= RESOLVE;
                    end
                end
                RESOLVE: state <= taken ? FLUSHED : IDLE;
                FLUSHED: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_PERF_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            br_count    <= 32'd0;
            taken_count <= 32'd0;
            stall_count <= 32'd0;
        end else if (!ext_stall) begin
            if (resolve_now) begin
                br_count <= br_count + 32'd1;
                if (taken) begin
                    taken_count <= taken_count + 32'd1;
                end
            end
            if (stall) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Scoreboard bench for branch_hazard_ctrl: directed scenarios then random traffic,
// checked against a stall-budget reference model.
module tb_branch_hazard_ctrl;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;
    localparam logic [6:0] OP_LD   = 7'b0000011;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] Instruction_ID;
    logic        RegWrite_EX, MemRead_EX, RegWrite_MEM, MemRead_MEM;
    logic [4:0]  rd_EX, rd_MEM;
    logic        ext_stall;
    logic [1:0]  PCSrc_cmp;
    logic        cmp_enable, stall, flush_IF;
    logic [1:0]  PCSrc;
`ifdef BRANCH_PERF_EN
    logic [31:0] br_count, taken_count, stall_count;
    logic [31:0] m_br, m_taken, m_stall;
`endif

    branch_hazard_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N), .Instruction_ID(Instruction_ID),
        .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .rd_EX(rd_EX),
        .RegWrite_MEM(RegWrite_MEM), .MemRead_MEM(MemRead_MEM), .rd_MEM(rd_MEM),
        .ext_stall(ext_stall), .PCSrc_cmp(PCSrc_cmp),
        .cmp_enable(cmp_enable), .stall(stall), .flush_IF(flush_IF), .PCSrc(PCSrc)
`ifdef BRANCH_PERF_EN
        , .br_count(br_count), .taken_count(taken_count), .stall_count(stall_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] exp;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference model: a held branch with a number of bubbles still owed
    // (-1 = nothing held), plus a pending one-cycle squash after a redirect.
    int   owed   = -1;
    bit   squash = 1'b0;

    function automatic logic [31:0] enc(logic [6:0] op, logic [4:0] s1, logic [4:0] s2, logic [4:0] rd);
        return {7'd0, s2, s1, 3'd0, rd, op};
    endfunction

    function automatic int bubbles(logic [31:0] ins, logic we_ex, logic ld_ex, logic [4:0] d_ex,
                                   logic we_mem, logic ld_mem, logic [4:0] d_mem);
        logic [6:0] op;
        bit r1, r2, ex_dep, mem_dep;
        op = ins[6:0];
        r1 = (op == OP_BR) || (op == OP_JALR);
        r2 = (op == OP_BR);
        ex_dep  = we_ex && d_ex != 0 && ((r1 && d_ex == ins[19:15]) || (r2 && d_ex == ins[24:20]));
        mem_dep = we_mem && d_mem != 0 && ((r1 && d_mem == ins[19:15]) || (r2 && d_mem == ins[24:20]));
        if (ex_dep) return ld_ex ? 2 : 1;
        if (mem_dep && ld_mem) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        owed   = -1;
        squash = 1'b0;
`ifdef BRANCH_PERF_EN
        m_br = 0; m_taken = 0; m_stall = 0;
`endif
    endtask

    task automatic apply(logic [31:0] ins, logic we_ex, logic ld_ex, logic [4:0] d_ex,
                         logic we_mem, logic ld_mem, logic [4:0] d_mem, logic ext, logic [1:0] pcs);
        logic e_stall, e_flush, e_cmp;
        logic [1:0] e_pc;
        bit res;
        int n;
        @(posedge CLK);
        #1;
        Instruction_ID = ins;
        RegWrite_EX = we_ex; MemRead_EX = ld_ex; rd_EX = d_ex;
        RegWrite_MEM = we_mem; MemRead_MEM = ld_mem; rd_MEM = d_mem;
        ext_stall = ext; PCSrc_cmp = pcs;
        e_stall = 0; e_flush = 0; e_cmp = 0; e_pc = 2'b00;
        res = 0;
        if (squash) begin
            if (!ext) squash = 0;
        end else if (owed > 0) begin
            e_stall = 1;
            if (!ext) owed--;
        end else if (owed == 0) begin
            res = 1;
        end else begin
            n = bubbles(ins, we_ex, ld_ex, d_ex, we_mem, ld_mem, d_mem);
            if ((ins[6:0] == OP_BR || ins[6:0] == OP_JALR) && n > 0) begin
                e_stall = 1;
                if (!ext) owed = n - 1;
            end else if (ins[6:0] == OP_BR || ins[6:0] == OP_JALR || ins[6:0] == OP_JAL) begin
                res = 1;
            end
        end
        if (res && !ext) begin
            e_cmp = 1;
            e_pc = pcs;
            e_flush = (pcs != 2'b00);
            squash = e_flush;
            owed = -1;
`ifdef BRANCH_PERF_EN
            m_br++;
            if (e_flush) m_taken++;
`endif
        end
`ifdef BRANCH_PERF_EN
        if (e_stall && !ext) m_stall++;
`endif
        sb.push_back('{exp: {e_stall, e_flush, e_cmp, e_pc}, cyc: cyc});
        cyc++;
    endtask

    task automatic nop();
        apply(enc(OP_ALU, 0, 0, 1), 0, 0, 0, 0, 0, 0, 0, 2'b00);
    endtask

    task automatic check_zero(string name);
        tests++;
        if ({stall, flush_IF, cmp_enable, PCSrc} !== 5'b0) begin
            fails++;
            $display("FAIL %s: outputs {stall,flush,cmp,pcsrc} got %b want 00000", name,
                     {stall, flush_IF, cmp_enable, PCSrc});
        end
    endtask

    // Asserts reset between edges with the current inputs still applied.
    task automatic reset_pulse(string name);
        @(negedge CLK);
        #1;
        RESET_N = 1'b0;
        #1;
        check_zero(name);
        Instruction_ID = 32'd0; RegWrite_EX = 0; MemRead_EX = 0; rd_EX = 0;
        RegWrite_MEM = 0; MemRead_MEM = 0; rd_MEM = 0; ext_stall = 0; PCSrc_cmp = 0;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        RESET_N = 1'b1;
        model_reset();
    endtask

    always @(negedge CLK) begin
        exp_t e;
        logic [4:0] got;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            got = {stall, flush_IF, cmp_enable, PCSrc};
            tests++;
            if (got !== e.exp) begin
                fails++;
                $display("FAIL cycle%0d outputs {stall,flush,cmp,pcsrc}: got %b want %b",
                         e.cyc, got, e.exp);
            end
        end
    end

    initial begin
        logic [31:0] beq56, bne70, jalr1, jal, beq00, rins;
        logic [6:0]  ops[5];
        beq56 = enc(OP_BR, 5, 6, 0);
        bne70 = enc(OP_BR, 7, 0, 0);
        jalr1 = enc(OP_JALR, 1, 0, 2);
        jal   = enc(OP_JAL, 1, 1, 1);
        beq00 = enc(OP_BR, 0, 0, 0);
        ops   = '{OP_BR, OP_JALR, OP_JAL, OP_ALU, OP_LD};

        RESET_N = 1'b0;
        Instruction_ID = beq56; RegWrite_EX = 1; MemRead_EX = 1; rd_EX = 5;
        RegWrite_MEM = 0; MemRead_MEM = 0; rd_MEM = 0; ext_stall = 0; PCSrc_cmp = 2'b01;
        #1;
        check_zero("reset_outputs");
        Instruction_ID = 32'd0; RegWrite_EX = 0; MemRead_EX = 0; rd_EX = 0; PCSrc_cmp = 0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        RESET_N = 1'b1;
        model_reset();

        // Load-use on BEQ: two bubbles, taken redirect, squash cycle
        apply(beq56, 1, 1, 5, 0, 0, 0, 0, 2'b00);
        apply(beq56, 1, 1, 5, 0, 0, 0, 0, 2'b00);
        apply(beq56, 1, 1, 5, 0, 0, 0, 0, 2'b01);
        apply(beq56, 1, 1, 5, 0, 0, 0, 0, 2'b01);
        nop();
        // ALU producer on BNE: one bubble, not taken
        apply(bne70, 1, 0, 7, 0, 0, 0, 0, 2'b00);
        apply(bne70, 1, 0, 7, 0, 0, 0, 0, 2'b00);
        nop();
        // JALR after MEM load; JAL never stalls
        apply(jalr1, 0, 0, 0, 1, 1, 1, 0, 2'b10);
        apply(jalr1, 0, 0, 0, 1, 1, 1, 0, 2'b10);
        apply(jalr1, 0, 0, 0, 1, 1, 1, 0, 2'b10);
        apply(jal,   1, 1, 1, 0, 0, 0, 0, 2'b01);
        apply(jal,   1, 1, 1, 0, 0, 0, 0, 2'b01);
        // x0 producer and RegWrite=0 producer never hazard
        apply(beq00, 1, 0, 0, 0, 0, 0, 0, 2'b01);
        apply(beq00, 1, 0, 0, 0, 0, 0, 0, 2'b01);
        apply(beq56, 0, 1, 6, 0, 0, 0, 0, 2'b00);
        // MEM non-load is forwarded
        apply(beq56, 0, 0, 0, 1, 0, 6, 0, 2'b00);
        // External freeze in the middle of the stall window
        apply(beq56, 1, 1, 5, 0, 0, 0, 0, 2'b00);
        repeat (3) apply(beq56, 1, 1, 5, 0, 0, 0, 1, 2'b01);
        apply(beq56, 1, 1, 5, 0, 0, 0, 0, 2'b00);
        apply(beq56, 1, 1, 5, 0, 0, 0, 0, 2'b00);
        nop();
        // Reset in the middle of a stall
        apply(beq56, 1, 1, 5, 0, 0, 0, 0, 2'b00);
        reset_pulse("reset_mid_stall");
        nop();

        for (int i = 0; i < 3000; i++) begin
            rins = enc(ops[$urandom_range(0, 4)], 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            apply(rins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 2)));
            if (i == 1500) begin
                reset_pulse("reset_random");
            end
        end

        @(negedge CLK);
        @(negedge CLK);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
`ifdef BRANCH_PERF_EN
        tests++;
        if (br_count !== m_br) begin
            fails++;
            $display("FAIL br_count: got %h want %h", br_count, m_br);
        end
        tests++;
        if (taken_count !== m_taken) begin
            fails++;
            $display("FAIL taken_count: got %h want %h", taken_count, m_taken);
        end
        tests++;
        if (stall_count !== m_stall) begin
            fails++;
            $display("FAIL stall_count: got %h want %h", stall_count, m_stall);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
